// File: rtl/poly_arith_pkg.sv
// rtl/poly_arith_pkg.sv - ML-KEM coefficient types, modulus and radix-16 residue tables
package poly_arith_pkg;

    typedef logic [11:0] coeff_t;

    localparam coeff_t KYBER_Q = 12'd3329;

    typedef enum logic {
        MODE_MUL    = 1'b0,
        MODE_MULADD = 1'b1
    } mul_mode_e;

    // k * 2^12 mod q
    function automatic coeff_t res_2p12(input logic [3:0] k);
        coeff_t r;
        case (k)
            4'd0:  r = 12'd0;
            4'd1:  r = 12'd767;
            4'd2:  r = 12'd1534;
            4'd3:  r = 12'd2301;
            4'd4:  r = 12'd3068;
            4'd5:  r = 12'd506;
            4'd6:  r = 12'd1273;
            4'd7:  r = 12'd2040;
            4'd8:  r = 12'd2807;
            4'd9:  r = 12'd245;
            4'd10: r = 12'd1012;
            4'd11: r = 12'd1779;
            4'd12: r = 12'd2546;
            4'd13: r = 12'd3313;
            4'd14: r = 12'd751;
            default: r = 12'd1518;
        endcase
        return r;
    endfunction

    // k * 2^16 mod q
    function automatic coeff_t res_2p16(input logic [3:0] k);
        coeff_t r;
        case (k)
            4'd0:  r = 12'd0;
            4'd1:  r = 12'd2285;
            4'd2:  r = 12'd1241;
            4'd3:  r = 12'd197;
            4'd4:  r = 12'd2482;
            4'd5:  r = 12'd1438;
            4'd6:  r = 12'd394;
            4'd7:  r = 12'd2679;
            4'd8:  r = 12'd1635;
            4'd9:  r = 12'd591;
            4'd10: r = 12'd2876;
            4'd11: r = 12'd1832;
            4'd12: r = 12'd788;
            4'd13: r = 12'd3073;
            4'd14: r = 12'd2029;
            default: r = 12'd985;
        endcase
        return r;
    endfunction

    // k * 2^20 mod q (2^20 = -59 mod q, so entries step down by 59)
    function automatic coeff_t res_2p20(input logic [3:0] k);
        coeff_t r;
        case (k)
            4'd0:  r = 12'd0;
            4'd1:  r = 12'd3270;
            4'd2:  r = 12'd3211;
            4'd3:  r = 12'd3152;
            4'd4:  r = 12'd3093;
            4'd5:  r = 12'd3034;
            4'd6:  r = 12'd2975;
            4'd7:  r = 12'd2916;
            4'd8:  r = 12'd2857;
            4'd9:  r = 12'd2798;
            4'd10: r = 12'd2739;
            4'd11: r = 12'd2680;
            4'd12: r = 12'd2621;
            4'd13: r = 12'd2562;
            4'd14: r = 12'd2503;
            default: r = 12'd2444;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/poly_mod_mul_if.sv
// rtl/poly_mod_mul_if.sv - beat handshake bundle between the multiplier and its neighbours
interface poly_mod_mul_if #(
    parameter int LANES = 2,
    parameter int TAG_W = 8
);
    logic                   valid_i;
    logic                   ready_o;
    logic                   mode_i;
    logic [LANES-1:0][11:0] a_i;
    logic [LANES-1:0][11:0] b_i;
    logic [LANES-1:0][11:0] c_i;
    logic [TAG_W-1:0]       tag_i;
    logic                   valid_o;
    logic                   ready_i;
    logic [LANES-1:0][11:0] result_o;
    logic [TAG_W-1:0]       tag_o;

    modport slave (
        input  valid_i, mode_i, a_i, b_i, c_i, tag_i, ready_i,
        output ready_o, valid_o, result_o, tag_o
    );

    modport master (
        output valid_i, mode_i, a_i, b_i, c_i, tag_i, ready_i,
        input  ready_o, valid_o, result_o, tag_o
    );
endinterface

// File: rtl/mod_lut_sum.sv
// rtl/mod_lut_sum.sv - folds a 24-bit product into a 14-bit sum congruent mod q
module mod_lut_sum
    import poly_arith_pkg::*;
(
    input  logic [23:0] p,
    output logic [13:0] sum
);
    // Upper three nibbles replaced by their residues; low 12 bits pass through
    assign sum = 14'(res_2p20(p[23:20])) + 14'(res_2p16(p[19:16]))
               + 14'(res_2p12(p[15:12])) + 14'(p[11:0]);
endmodule

// File: rtl/poly_mod_mul.sv
// rtl/poly_mod_mul.sv - 3-stage bubble-collapsing modular multiply / multiply-add, q = 3329
module poly_mod_mul
    import poly_arith_pkg::*;
#(
    parameter int LANES = 2,
    parameter int TAG_W = 8
) (
    input logic           clk,
    input logic           rst,
    poly_mod_mul_if.slave bus
);
    localparam logic [13:0] Q1 = 14'(KYBER_Q);
    localparam logic [13:0] Q2 = 14'd2 * Q1;
    localparam logic [13:0] Q3 = 14'd3 * Q1;
    localparam logic [13:0] Q4 = 14'd4 * Q1;

    // Subtract the largest multiple of q not exceeding the table sum (sum <= 14079 < 5q)
    function automatic coeff_t reduce_sum(input logic [13:0] s);
        logic [13:0] r;
        if (s >= Q4)      r = s - Q4;
        else if (s >= Q3) r = s - Q3;
        else if (s >= Q2) r = s - Q2;
        else if (s >= Q1) r = s - Q1;
        else              r = s;
        return coeff_t'(r);
    endfunction

    logic                   v1, v2, v3;
    logic                   en1, en2, en3;
    logic [LANES-1:0][23:0] p1;
    logic [LANES-1:0][13:0] s2;
    logic [LANES-1:0][11:0] r3;
    logic [TAG_W-1:0]       t1, t2, t3;
    logic [23:0]            p_nxt [LANES];
    logic [13:0]            s_nxt [LANES];

    // A stage may load when it is empty or its contents move on this edge
    assign en3 = !v3 || bus.ready_i;
    assign en2 = !v2 || en3;
    assign en1 = !v1 || en2;

    assign bus.ready_o  = en1;
    assign bus.valid_o  = v3;
    assign bus.result_o = r3;
    assign bus.tag_o    = t3;

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        assign p_nxt[l] = 24'(bus.a_i[l]) * 24'(bus.b_i[l])
                        + ((mul_mode_e'(bus.mode_i) == MODE_MULADD) ? 24'(bus.c_i[l]) : 24'd0);
        mod_lut_sum u_lut (
            .p   (p1[l]),
            .sum (s_nxt[l])
        );
    end

    // S1: capture the raw product (plus addend) when a beat is taken
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1 <= 1'b0;
            p1 <= '0;
            t1 <= '0;
        end else if (en1) begin
            v1 <= bus.valid_i;
            if (bus.valid_i) begin
                for (int i = 0; i < LANES; i++) p1[i] <= p_nxt[i];
                t1 <= bus.tag_i;
            end
        end
    end

    // S2: register the folded table sum
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v2 <= 1'b0;
            s2 <= '0;
            t2 <= '0;
        end else if (en2) begin
            v2 <= v1;
            if (v1) begin
                for (int i = 0; i < LANES; i++) s2[i] <= s_nxt[i];
                t2 <= t1;
            end
        end
    end

    // S3: final conditional subtraction into [0, q-1]; held while downstream stalls
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v3 <= 1'b0;
            r3 <= '0;
            t3 <= '0;
        end else if (en3) begin
            v3 <= v2;
            if (v2) begin
                for (int i = 0; i < LANES; i++) r3[i] <= reduce_sum(s2[i]);
                t3 <= t2;
            end
        end
    end
endmodule

// File: tb/tb_poly_mod_mul.sv
// tb/tb_poly_mod_mul.sv - self-checking bench for poly_mod_mul
module tb_poly_mod_mul;
    localparam int Q = 3329;
    localparam int N_STREAM = 10000;

    typedef struct {
        bit mode;
        int a0, b0, c0;
        int a1, b1, c1;
        int tag;
        int e0, e1;
    } beat_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;
    beat_t sb[$];
    beat_t vecs[8];

    always #5 clk = ~clk;

    poly_mod_mul_if #(.LANES(2), .TAG_W(8)) bus ();

    poly_mod_mul #(.LANES(2), .TAG_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    function automatic int model(input bit mode, input int a, input int b, input int c);
        return (a * b + (mode ? c : 0)) % Q;
    endfunction

    function automatic beat_t vec(input bit mode, input int a0, input int b0, input int c0,
                                  input int a1, input int b1, input int c1, input int tag,
                                  input int e0, input int e1);
        beat_t bt;
        bt.mode = mode; bt.a0 = a0; bt.b0 = b0; bt.c0 = c0;
        bt.a1 = a1; bt.b1 = b1; bt.c1 = c1; bt.tag = tag;
        bt.e0 = e0; bt.e1 = e1;
        return bt;
    endfunction

    function automatic beat_t rnd_beat();
        beat_t bt;
        bt.mode = 1'($urandom_range(0, 1));
        bt.a0 = int'($urandom_range(0, 4095)); bt.b0 = int'($urandom_range(0, 4095));
        bt.c0 = int'($urandom_range(0, 4095)); bt.a1 = int'($urandom_range(0, 4095));
        bt.b1 = int'($urandom_range(0, 4095)); bt.c1 = int'($urandom_range(0, 4095));
        bt.tag = int'($urandom_range(0, 255));
        bt.e0 = model(bt.mode, bt.a0, bt.b0, bt.c0);
        bt.e1 = model(bt.mode, bt.a1, bt.b1, bt.c1);
        return bt;
    endfunction

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic drive(input beat_t bt);
        bus.valid_i  = 1'b1;
        bus.mode_i   = bt.mode;
        bus.a_i[0]   = 12'(bt.a0); bus.b_i[0] = 12'(bt.b0); bus.c_i[0] = 12'(bt.c0);
        bus.a_i[1]   = 12'(bt.a1); bus.b_i[1] = 12'(bt.b1); bus.c_i[1] = 12'(bt.c1);
        bus.tag_i    = 8'(bt.tag);
    endtask

    task automatic check_out(input string name, input beat_t bt);
        check({name, "_lane0"}, int'(bus.result_o[0]), bt.e0);
        check({name, "_lane1"}, int'(bus.result_o[1]), bt.e1);
        check({name, "_tag"}, int'(bus.tag_o), bt.tag);
    endtask

    // Entered and left at posedge+1; one beat through an empty pipe with ready_i = 1
    task automatic run_vec(input string name, input beat_t bt);
        drive(bt);
        @(negedge clk);
        check({name, "_ready"}, int'(bus.ready_o), 1);
        @(posedge clk);
        #1 bus.valid_i = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check({name, "_early"}, int'(bus.valid_o), 0);
        @(posedge clk);
        @(negedge clk);
        check({name, "_valid"}, int'(bus.valid_o), 1);
        check_out(name, bt);
        @(posedge clk);
        #1;
    endtask

    // Collect handshaken outputs for a fixed number of cycles against the scoreboard
    task automatic drain(input string name, input int n, input int budget);
        int got = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (bus.valid_o && bus.ready_i) begin
                if (sb.size() > 0) check_out(name, sb.pop_front());
                got++;
            end
            @(posedge clk);
            #1;
        end
        check({name, "_count"}, got, n);
        check({name, "_left"}, sb.size(), 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        beat_t bp[4];
        beat_t bb[4];
        beat_t bt;
        int sent, rcvd, gaps, stalls;
        bit started;

        bus.valid_i = 1'b0; bus.mode_i = 1'b0; bus.ready_i = 1'b1;
        bus.a_i = '0; bus.b_i = '0; bus.c_i = '0; bus.tag_i = '0;

        //            mode  a0    b0    c0    a1    b1    c1   tag   e0    e1
        vecs[0] = vec(1'b0, 3328, 3328, 0,    2,    1665, 0,   'h5A, 1,    1);
        vecs[1] = vec(1'b1, 3328, 3328, 3328, 4095, 4095, 4095,'h11, 0,    1618);
        vecs[2] = vec(1'b1, 0,    4095, 0,    1,    1,    3328,'h22, 0,    0);
        vecs[3] = vec(1'b0, 0,    0,    0,    4095, 4095, 0,   'h33, 0,    852);
        vecs[4] = vec(1'b0, 3000, 3000, 0,    1234, 2345, 0,   'h44, 1713, 829);
        vecs[5] = vec(1'b1, 100,  100,  5,    0,    0,    4095,'h55, 18,   766);
        vecs[6] = vec(1'b0, 1,    4095, 4000, 1,    3329, 7,   'hA5, 766,  0);
        vecs[7] = vec(1'b1, 0,    0,    3329, 12,   12,   0,   'hFF, 0,    144);

        repeat (3) @(posedge clk);
        #1;
        check("rst_valid_o", int'(bus.valid_o), 0);
        check("rst_result0", int'(bus.result_o[0]), 0);
        check("rst_result1", int'(bus.result_o[1]), 0);
        check("rst_tag_o", int'(bus.tag_o), 0);
        rst = 1'b0;
        #1;
        check("rst_ready_o", int'(bus.ready_o), 1);
        @(posedge clk);
        #1;

        for (int i = 0; i < 8; i++) run_vec($sformatf("vec%0d", i), vecs[i]);

        // Sustained streaming at one beat per cycle
        sent = 0; rcvd = 0; gaps = 0; stalls = 0; started = 1'b0;
        for (int cyc = 0; cyc < N_STREAM + 20 && rcvd < N_STREAM; cyc++) begin
            if (sent < N_STREAM) begin
                bt = rnd_beat();
                drive(bt);
            end else begin
                bus.valid_i = 1'b0;
            end
            @(negedge clk);
            if (bus.valid_o) begin
                started = 1'b1;
                if (sb.size() > 0) check_out("stream", sb.pop_front());
                else check("stream_extra", 1, 0);
                rcvd++;
            end else if (started) begin
                gaps++;
            end
            if (bus.valid_i) begin
                if (bus.ready_o) begin
                    sb.push_back(bt);
                    sent++;
                end else begin
                    stalls++;
                end
            end
            @(posedge clk);
            #1;
        end
        bus.valid_i = 1'b0;
        check("stream_count", rcvd, N_STREAM);
        check("stream_gaps", gaps, 0);
        check("stream_stalls", stalls, 0);
        sb.delete();

        // Backpressure: three beats fill the pipe, a fourth is refused
        bp[0] = vec(1'b0, 3328, 3328, 0, 2, 1665, 0, 'h01, 1, 1);
        bp[1] = vec(1'b1, 4095, 4095, 4095, 100, 100, 5, 'h02, 1618, 18);
        bp[2] = vec(1'b0, 3000, 3000, 0, 1234, 2345, 0, 'h03, 1713, 829);
        bp[3] = vec(1'b0, 1, 1, 0, 1, 2, 0, 'h04, 1, 2);
        bus.ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(bp[i]);
            @(negedge clk);
            check($sformatf("bp_ready%0d", i), int'(bus.ready_o), 1);
            @(posedge clk);
            #1;
            sb.push_back(bp[i]);
        end
        drive(bp[3]);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_full_ready", int'(bus.ready_o), 0);
            check("bp_hold_valid", int'(bus.valid_o), 1);
            check_out("bp_hold", bp[0]);
            @(posedge clk);
            #1;
        end
        bus.valid_i = 1'b0;
        bus.ready_i = 1'b1;
        drain("bp_drain", 3, 8);

        // Bubble collapse: gaps close up behind a stalled output
        bb[0] = vec(1'b1, 3328, 3328, 3328, 4095, 4095, 4095, 'hB1, 0, 1618);
        bb[1] = vec(1'b0, 2, 3, 0, 4, 5, 0, 'hB2, 6, 20);
        bb[2] = vec(1'b1, 10, 10, 1, 0, 0, 7, 'hB3, 101, 7);
        bb[3] = vec(1'b0, 0, 0, 0, 0, 0, 0, 'hB4, 0, 0);
        drive(bb[0]);
        @(negedge clk);
        check("bub_ready0", int'(bus.ready_o), 1);
        @(posedge clk);
        #1 bus.valid_i = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        bus.ready_i = 1'b0;
        drive(bb[1]);
        @(negedge clk);
        check("bub_ready1", int'(bus.ready_o), 1);
        check("bub_valid1", int'(bus.valid_o), 1);
        check_out("bub_head", bb[0]);
        @(posedge clk);
        #1 bus.valid_i = 1'b0;
        @(negedge clk);
        check("bub_ready_idle", int'(bus.ready_o), 1);
        @(posedge clk);
        #1;
        drive(bb[2]);
        @(negedge clk);
        check("bub_ready2", int'(bus.ready_o), 1);
        check_out("bub_head_stall", bb[0]);
        @(posedge clk);
        #1;
        drive(bb[3]);
        @(negedge clk);
        check("bub_full_ready", int'(bus.ready_o), 0);
        @(posedge clk);
        #1;
        bus.valid_i = 1'b0;
        bus.ready_i = 1'b1;
        sb.push_back(bb[0]);
        sb.push_back(bb[1]);
        sb.push_back(bb[2]);
        drain("bub_drain", 3, 8);

        // Reset with the pipe full discards everything in flight
        bus.ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(bp[i]);
            @(posedge clk);
            #1;
        end
        bus.valid_i = 1'b0;
        @(negedge clk);
        check("mid_full_valid", int'(bus.valid_o), 1);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_valid", int'(bus.valid_o), 0);
        check("mid_rst_ready", int'(bus.ready_o), 1);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        bus.ready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("post_rst_quiet", int'(bus.valid_o), 0);
            @(posedge clk);
            #1;
        end
        run_vec("post_rst", vecs[4]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
